// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register stage that decodes the ID instruction into ALU control, operands and mem/wb controls.
// Optional: define ALU_ISSUE_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
`default_nettype none

module alu_issue_stage #(
  parameter int ZERO_REG_SUPPRESS = 1,
  parameter int ILLEGAL_AS_BUBBLE = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_aluc,
  output logic        ex_wreg,
  output logic [4:0]  ex_rn,
  output logic        ex_m2reg,
  output logic        ex_wmem,
  output logic [31:0] ex_st_data,
  output logic        ex_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [7:0]  illegal_cnt
`endif
);

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = id_inst[31:26];
  assign rt       = id_inst[20:16];
  assign rd       = id_inst[15:11];
  assign sa       = id_inst[10:6];
  assign funct    = id_inst[5:0];
  assign imm_sext = {{16{id_inst[15]}}, id_inst[15:0]};
  assign imm_zext = {16'b0, id_inst[15:0]};

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_aluc;
  logic [4:0]  dec_rn;
  logic        dec_wreg;
  logic        dec_m2reg;
  logic        dec_wmem;
  logic        dec_ill;

  always_comb begin
    dec_a     = id_rs_val;
    dec_b     = id_rt_val;
    dec_aluc  = ALUC_ADD;
    dec_rn    = rd;
    dec_wreg  = 1'b1;
    dec_m2reg = 1'b0;
    dec_wmem  = 1'b0;
    dec_ill   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: dec_aluc = ALUC_ADD;
          FN_SUB: dec_aluc = ALUC_SUB;
          FN_AND: dec_aluc = ALUC_AND;
          FN_OR:  dec_aluc = ALUC_OR;
          FN_XOR: dec_aluc = ALUC_XOR;
          FN_SLL: begin dec_aluc = ALUC_SLL; dec_a = {27'b0, sa}; end
          FN_SRL: begin dec_aluc = ALUC_SRL; dec_a = {27'b0, sa}; end
          FN_SRA: begin dec_aluc = ALUC_SRA; dec_a = {27'b0, sa}; end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_ADDI: begin dec_aluc = ALUC_ADD; dec_b = imm_sext; dec_rn = rt; end
      OP_ANDI: begin dec_aluc = ALUC_AND; dec_b = imm_zext; dec_rn = rt; end
      OP_ORI:  begin dec_aluc = ALUC_OR;  dec_b = imm_zext; dec_rn = rt; end
      OP_XORI: begin dec_aluc = ALUC_XOR; dec_b = imm_zext; dec_rn = rt; end
      OP_LUI:  begin dec_aluc = ALUC_LUI; dec_b = imm_zext; dec_rn = rt; end
      OP_LW: begin
        dec_aluc  = ALUC_ADD;
        dec_b     = imm_sext;
        dec_rn    = rt;
        dec_m2reg = 1'b1;
      end
      OP_SW: begin
        dec_aluc = ALUC_ADD;
        dec_b    = imm_sext;
        dec_rn   = rt;
        dec_wmem = 1'b1;
        dec_wreg = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        dec_aluc = ALUC_SUB;
        dec_rn   = rt;
        dec_wreg = 1'b0;
      end
      default: dec_ill = 1'b1;
    endcase

    // Undecodable words carry no operands and can never write anything.
    if (dec_ill) begin
      dec_a     = 32'b0;
      dec_b     = 32'b0;
      dec_aluc  = ALUC_ADD;
      dec_rn    = 5'b0;
      dec_wreg  = 1'b0;
      dec_m2reg = 1'b0;
      dec_wmem  = 1'b0;
    end else if ((ZERO_REG_SUPPRESS != 0) && (dec_rn == 5'b0)) begin
      dec_wreg = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_valid   <= 1'b0;
      ex_a       <= 32'b0;
      ex_b       <= 32'b0;
      ex_aluc    <= 4'b0;
      ex_wreg    <= 1'b0;
      ex_rn      <= 5'b0;
      ex_m2reg   <= 1'b0;
      ex_wmem    <= 1'b0;
      ex_st_data <= 32'b0;
      ex_illegal <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid   <= 1'b0;
      ex_a       <= 32'b0;
      ex_b       <= 32'b0;
      ex_aluc    <= 4'b0;
      ex_wreg    <= 1'b0;
      ex_rn      <= 5'b0;
      ex_m2reg   <= 1'b0;
      ex_wmem    <= 1'b0;
      ex_st_data <= 32'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= ~dec_ill | (ILLEGAL_AS_BUBBLE == 0);
      ex_a       <= dec_a;
      ex_b       <= dec_b;
      ex_aluc    <= dec_aluc;
      ex_wreg    <= dec_wreg;
      ex_rn      <= dec_rn;
      ex_m2reg   <= dec_m2reg;
      ex_wmem    <= dec_wmem;
      ex_st_data <= id_rt_val;
      ex_illegal <= dec_ill;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      illegal_cnt <= 8'b0;
    end else if (!flush && !stall && id_valid && dec_ill && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: stimulus pushes model predictions, a negedge monitor pops and compares.
`default_nettype none

module tb_alu_issue_stage;

  logic        clock;
  logic        resetn;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_aluc;
  logic        ex_wreg;
  logic [4:0]  ex_rn;
  logic        ex_m2reg;
  logic        ex_wmem;
  logic [31:0] ex_st_data;
  logic        ex_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [7:0]  illegal_cnt;
`endif

  alu_issue_stage #(.ZERO_REG_SUPPRESS(1), .ILLEGAL_AS_BUBBLE(1)) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_inst(id_inst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_wreg(ex_wreg), .ex_rn(ex_rn), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_st_data(ex_st_data), .ex_illegal(ex_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        wreg;
    logic [4:0]  rn;
    logic        m2reg;
    logic        wmem;
    logic [31:0] st;
    logic        ill;
    logic        dp_care;
    logic [7:0]  cnt;
  } exp_t;

  exp_t model;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference decode written from the instruction table: mnemonic -> ALU code and operand choice.
  function automatic exp_t decode(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] sx;
    logic [31:0] zx;
    logic ok;
    op = inst[31:26];
    fn = inst[5:0];
    sx = 32'($signed(inst[15:0]));
    zx = 32'(inst[15:0]);
    e = '0;
    e.valid = 1'b1;
    e.dp_care = 1'b1;
    e.st = rt;
    e.a = rs;
    e.b = rt;
    e.wreg = 1'b1;
    e.rn = inst[20:16];
    ok = 1'b1;
    if (op == 6'h00) begin
      e.rn = inst[15:11];
      case (fn)
        6'h20: e.aluc = 4'h0;
        6'h22: e.aluc = 4'h4;
        6'h24: e.aluc = 4'h1;
        6'h25: e.aluc = 4'h5;
        6'h26: e.aluc = 4'h2;
        6'h00: begin e.aluc = 4'h3; e.a = 32'(inst[10:6]); end
        6'h02: begin e.aluc = 4'h7; e.a = 32'(inst[10:6]); end
        6'h03: begin e.aluc = 4'hF; e.a = 32'(inst[10:6]); end
        default: ok = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08: begin e.aluc = 4'h0; e.b = sx; end
        6'h0C: begin e.aluc = 4'h1; e.b = zx; end
        6'h0D: begin e.aluc = 4'h5; e.b = zx; end
        6'h0E: begin e.aluc = 4'h2; e.b = zx; end
        6'h0F: begin e.aluc = 4'h6; e.b = zx; end
        6'h23: begin e.aluc = 4'h0; e.b = sx; e.m2reg = 1'b1; end
        6'h2B: begin e.aluc = 4'h0; e.b = sx; e.wmem = 1'b1; e.wreg = 1'b0; end
        6'h04, 6'h05: begin e.aluc = 4'h4; e.wreg = 1'b0; end
        default: ok = 1'b0;
      endcase
    end
    if (e.rn == 5'd0) e.wreg = 1'b0;
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t step(input exp_t p, input logic v, input logic [31:0] inst,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic st, input logic fl);
    exp_t n;
    if (fl || (!st && !v)) begin
      n = '0;
      n.dp_care = 1'b1;
      n.cnt = p.cnt;
    end else if (st) begin
      n = p;
    end else begin
      n = decode(inst, rs, rt);
      n.cnt = (n.ill && p.cnt != 8'hFF) ? p.cnt + 8'd1 : p.cnt;
    end
    return n;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl);
    id_valid = v; id_inst = inst; id_rs_val = rs; id_rt_val = rt; stall = st; flush = fl;
    @(posedge clock);
    model = step(model, v, inst, rs, rt, st, fl);
    q.push_back(model);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [10];
    logic [5:0] fns [8];
    logic [31:0] w;
    int k;
    ops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03};
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k < 8) w = {6'h00, w[25:6], fns[k]};
    else if (k < 18) w = {ops[k-8], w[25:0]};
    else if (k == 18) w = {6'h02, w[25:0]};
    else w = {6'h00, w[25:6], 6'h08};
    return w;
  endfunction

  task automatic chk_zero_now();
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst ex_a", ex_a, 32'd0);
    chk("rst ex_b", ex_b, 32'd0);
    chk("rst ex_aluc", 32'(ex_aluc), 32'd0);
    chk("rst ex_wreg", 32'(ex_wreg), 32'd0);
    chk("rst ex_rn", 32'(ex_rn), 32'd0);
    chk("rst ex_m2reg", 32'(ex_m2reg), 32'd0);
    chk("rst ex_wmem", 32'(ex_wmem), 32'd0);
    chk("rst ex_st_data", ex_st_data, 32'd0);
    chk("rst ex_illegal", 32'(ex_illegal), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("rst illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_aluc", 32'(ex_aluc), 32'(e.aluc));
      chk("ex_wreg", 32'(ex_wreg), 32'(e.wreg));
      chk("ex_m2reg", 32'(ex_m2reg), 32'(e.m2reg));
      chk("ex_wmem", 32'(ex_wmem), 32'(e.wmem));
      chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
      if (e.dp_care) begin
        chk("ex_a", ex_a, e.a);
        chk("ex_b", ex_b, e.b);
        chk("ex_rn", 32'(ex_rn), 32'(e.rn));
        chk("ex_st_data", ex_st_data, e.st);
      end
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
      chk("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    model = '0;
    resetn = 1'b0; id_valid = 1'b0; id_inst = '0; id_rs_val = '0; id_rt_val = '0;
    stall = 1'b0; flush = 1'b0;
    #12;
    chk_zero_now();
    @(negedge clock);
    resetn = 1'b1;

    cycle(1'b1, 32'h2022FFFC, 32'h10, 32'h55, 1'b0, 1'b0);        // addi $2,$1,-4
    cycle(1'b1, 32'h00021900, 32'h77, 32'h0000000F, 1'b0, 1'b0);  // sll $3,$2,4
    cycle(1'b1, 32'h30218000, 32'h1234ABCD, 32'h9, 1'b0, 1'b0);   // andi
    cycle(1'b1, 32'h3C051234, 32'h0, 32'h0, 1'b0, 1'b0);          // lui $5
    cycle(1'b1, 32'h00000000, 32'h0, 32'h0, 1'b0, 1'b0);          // sll r0: legal, no write
    cycle(1'b1, 32'h8C43FFF0, 32'h1000, 32'hAA, 1'b0, 1'b0);      // lw
    cycle(1'b1, 32'hAC430008, 32'h2000, 32'hBB, 1'b0, 1'b0);      // sw
    cycle(1'b1, 32'h10430004, 32'h5, 32'h5, 1'b0, 1'b0);          // beq
    cycle(1'b1, 32'h00430820, 32'h11, 32'h22, 1'b0, 1'b0);        // add $1,$2,$3
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    cycle(1'b1, 32'h00430820, 32'h1, 32'h2, 1'b1, 1'b1);          // stall+flush
    cycle(1'b1, 32'hFC000000, 32'h3, 32'h4, 1'b0, 1'b0);          // illegal
    cycle(1'b0, 32'h00430820, 32'h3, 32'h4, 1'b0, 1'b0);          // id_valid=0 bubble

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) != 0), rand_inst(), $urandom, $urandom,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));

    for (int i = 0; i < 300; i++) cycle(1'b1, 32'hFC000000, $urandom, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hFC000000, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'hFC000000, 32'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-stall with a valid instruction held.
    cycle(1'b1, 32'h00430820, 32'h11, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h2022FFFC, 32'h1, 32'h2, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk_zero_now();
    model = '0;
    #2;
    resetn = 1'b1;
    cycle(1'b1, 32'h3C051234, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      cycle(($urandom_range(0, 9) != 0), rand_inst(), $urandom, $urandom,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage that drives the EX-stage ALU. It decodes the ID instruction into the ALU control code and the a/b operands, plus writeback and memory controls, and registers them. This is the sending end of the ALU operand/control interface. Output-to-ALU latency is one cycle, with stall and flush handshakes from the hazard unit.

Parameters:
ZERO_REG_SUPPRESS, 1, when 1 a destination of r0 forces ex_wreg=0.
ILLEGAL_AS_BUBBLE, 1, when 1 an undecodable instruction is registered as a bubble (ex_valid=0); when 0 it is registered valid with all write enables 0.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_inst  in  32  instruction word
id_rs_val  in  32  forwarded rs value
id_rt_val  in  32  forwarded rt value
stall  in  1  hold all EX registers
flush  in  1  load a bubble
ex_valid  out  1  EX holds a real instruction
ex_a  out  32  ALU operand a
ex_b  out  32  ALU operand b
ex_aluc  out  4  ALU control code
ex_wreg  out  1  register writeback enable
ex_rn  out  5  destination register
ex_m2reg  out  1  writeback from memory (lw)
ex_wmem  out  1  memory write (sw)
ex_st_data  out  32  store data (rt value)
ex_illegal  out  1  registered instruction was undecodable

Behaviour:
- Reset (resetn=0, asynchronous): all outputs 0 immediately and held 0 until the first clock edge after release.
- Priority at each clock edge: flush > stall > load.
  - flush=1: ex_valid, ex_wreg, ex_wmem, ex_m2reg and ex_illegal go to 0. Datapath outputs go to 0.
  - stall=1 and flush=0: every output holds its value.
  - Otherwise: outputs load from the decode of id_inst, qualified by id_valid. If id_valid=0, the stage loads a bubble, same as flush.
- ALU control codes (ex_aluc):
  - ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- R-type decode (op=000000), keyed on funct:
  - add 100000 and sub 100010: a=rs, b=rt, rn=rd.
  - and 100100, or 100101, xor 100110: a=rs, b=rt, rn=rd.
  - sll 000000, srl 000010, sra 000011: a={27'b0, sa}, b=rt, rn=rd.
- I-type decode (rn=rt unless stated):
  - addi 001000: ADD, b=sign-extended imm.
  - andi 001100, ori 001101, xori 001110: b=zero-extended imm.
  - lui 001111: LUI, b={16'b0, imm}; the ALU performs the shift.
  - lw 100011: ADD, sign-extended imm, m2reg=1.
  - sw 101011: ADD, sign-extended imm, wmem=1, wreg=0.
  - beq 000100 and bne 000101: SUB, a=rs, b=rt, wreg=0.
- ex_st_data = rt value for every instruction.
- Any other op or funct sets ex_illegal=1 and ex_aluc=0000, with wreg, wmem and m2reg all 0. ex_valid then follows ILLEGAL_AS_BUBBLE.
- With ZERO_REG_SUPPRESS=1, rn=0 forces ex_wreg=0. ex_rn still records 0.
- Encoding 0x00000000 (sll r0,r0,0) decodes legally as SLL with wreg suppressed.
- resetn asserted mid-stall clears the outputs; the stalled instruction is lost.

Optional Feature:
ALU_ISSUE_ILLEGAL_CNT_EN:
- Defined: adds output illegal_cnt (8 bits). It increments on each clock edge that loads an illegal instruction with id_valid=1, stall=0 and flush=0. It saturates at 255 and resets to 0 on resetn. Stalled or flushed cycles never count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- addi $2,$1,-4 (0x2022FFFC), rs_val=0x10, id_valid=1 -> next edge: ex_a=0x10, ex_b=0xFFFFFFFC, ex_aluc=0000, ex_wreg=1, ex_rn=2, ex_valid=1.
- sll $3,$2,4 (0x00021900), rt_val=0x0000000F -> ex_a=0x4, ex_b=0xF, ex_aluc=0011, ex_rn=3.
- andi $1,$1,0x8000 (0x30218000) -> ex_b=0x00008000 (zero-extended), ex_aluc=0001. Then lui $5,0x1234 (0x3C051234) -> ex_b=0x00001234, ex_aluc=0110, ex_rn=5.
- Load add, then assert stall for 3 cycles while id_inst changes -> all outputs constant. Then stall=1 and flush=1 together -> ex_valid=0, ex_wreg=0.
- id_inst=0xFC000000 with id_valid=1 -> ex_illegal=1, ex_valid=0, all enables 0. With ALU_ISSUE_ILLEGAL_CNT_EN, 300 such loads -> illegal_cnt=255.
- Drive resetn low asynchronously mid-cycle while ex_valid=1 -> all outputs 0 before the next clock edge.
